minterm_sweep_checker: RTL and testbench

- Parametrised hardware self-test engine for combinational lab circuits.
- Drives every input vector 0 .. 2^N_IN-1 onto a combinational DUT, waits a settle time, then compares the DUT output against a programmable minterm mask.
- Counts missing-minterm and extra-minterm errors separately, and records the first failing vector.
- Sits beside the DUT on the board so a sweep can run without a simulator.

---
 rtl/minterm_pkg.sv | 20 ++
 rtl/settle_timer.sv | 32 +++
 rtl/minterm_sweep_checker.sv | 149 ++++++++++++++
 tb/tb_minterm_sweep_checker.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/minterm_pkg.sv
// Shared definitions for the minterm sweep checker and its sub-blocks.
//   state_t   : sweep FSM state encoding.
//   SETTLE_W  : width of the settle down-counter. It covers SETTLE_CYCLES up to 255.
//   vec_count : the number of input vectors in a sweep of an n_in-bit DUT.
package minterm_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        FIN    = 2'd3
    } state_t;

    localparam int SETTLE_W = 8;

    function automatic int vec_count(input int n_in);
        return 1 << n_in;
    endfunction

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter with a zero flag. The counter stops at zero.
//   clk, rst  : rising-edge clock and synchronous active-high reset (count is cleared)
//   load      : load load_val (load has priority over dec)
//   load_val  : reload value
//   dec       : decrement by one when the count is nonzero
//   zero      : high while the count is zero
module settle_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/minterm_sweep_checker.sv
// Hardware self-test engine for a combinational lab circuit. The block drives each
// vector from 0 to 2^N_IN-1 on sel and holds it for SETTLE_CYCLES cycles. In the next
// cycle it compares dut_o with the latched minterm mask. It counts missing minterms and
// extra minterms separately, and it records the lowest failing vector.
//
// Ports:
//   clk, rst        : rising-edge clock and synchronous active-high reset
//   start           : sweep request. Only IDLE samples it; a start seen in any
//                     other state is dropped and is not queued.
//   minterm_mask    : bit i is the expected DUT output for vector i. It is latched on start.
//   dut_o           : DUT output (combinational function of sel)
//   sel             : vector currently driven to the DUT
//   busy            : sweep in progress (SETTLE/CHECK)
//   done            : one-cycle pulse (the FIN state)
//   pass            : both error counts are zero. This output is valid from done onward.
//   miss_cnt        : vectors where the output was expected 1 and read 0
//   extra_cnt       : vectors where the output was expected 0 and read 1
//   first_fail      : lowest failing vector
//   first_fail_vld  : first_fail holds a real value
//   state_dbg       : current FSM state, for observation
module minterm_sweep_checker
    import minterm_pkg::*;
#(
    parameter int N_IN          = 4,
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = N_IN + 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [vec_count(N_IN)-1:0] minterm_mask,
    input  logic                       dut_o,
    output logic [N_IN-1:0]            sel,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic [CNT_W-1:0]           miss_cnt,
    output logic [CNT_W-1:0]           extra_cnt,
    output logic [N_IN-1:0]            first_fail,
    output logic                       first_fail_vld,
    output state_t                     state_dbg
);

    localparam int                  VEC         = vec_count(N_IN);
    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);

    state_t            state, state_nxt;
    logic [VEC-1:0]    mask_q, mask_nxt;
    logic [N_IN-1:0]   sel_nxt, ff_nxt;
    logic [CNT_W-1:0]  miss_nxt, extra_nxt;
    logic              ffv_nxt, pass_nxt;
    logic              tmr_load, tmr_dec, tmr_zero;
    logic              exp_bit, is_miss, is_extra, last_vec;

    settle_timer #(.W(SETTLE_W)) u_settle_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (SETTLE_LOAD),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    assign exp_bit  = mask_q[sel];
    assign is_miss  = exp_bit & ~dut_o;
    assign is_extra = ~exp_bit & dut_o;
    assign last_vec = (sel == N_IN'(VEC - 1));

    always_comb begin
        state_nxt = state;
        mask_nxt  = mask_q;
        sel_nxt   = sel;
        miss_nxt  = miss_cnt;
        extra_nxt = extra_cnt;
        ff_nxt    = first_fail;
        ffv_nxt   = first_fail_vld;
        pass_nxt  = pass;
        tmr_load  = 1'b0;
        tmr_dec   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    mask_nxt  = minterm_mask;
                    miss_nxt  = '0;
                    extra_nxt = '0;
                    ffv_nxt   = 1'b0;
                    pass_nxt  = 1'b0;
                    sel_nxt   = '0;
                    tmr_load  = 1'b1;
                    state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                if (tmr_zero) state_nxt = CHECK;
                else          tmr_dec   = 1'b1;
            end
            CHECK: begin
                if (is_miss)  miss_nxt  = miss_cnt + CNT_W'(1);
                if (is_extra) extra_nxt = extra_cnt + CNT_W'(1);
                if ((is_miss || is_extra) && !first_fail_vld) begin
                    ff_nxt  = sel;
                    ffv_nxt = 1'b1;
                end
                if (last_vec) begin
                    // Compute pass from the final counts so that it is already valid in the done cycle.
                    pass_nxt  = (miss_nxt == '0) && (extra_nxt == '0);
                    state_nxt = FIN;
                end else begin
                    sel_nxt   = sel + N_IN'(1);
                    tmr_load  = 1'b1;
                    state_nxt = SETTLE;
                end
            end
            FIN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            mask_q         <= '0;
            sel            <= '0;
            miss_cnt       <= '0;
            extra_cnt      <= '0;
            first_fail     <= '0;
            first_fail_vld <= 1'b0;
            pass           <= 1'b0;
        end else begin
            state          <= state_nxt;
            mask_q         <= mask_nxt;
            sel            <= sel_nxt;
            miss_cnt       <= miss_nxt;
            extra_cnt      <= extra_nxt;
            first_fail     <= ff_nxt;
            first_fail_vld <= ffv_nxt;
            pass           <= pass_nxt;
        end
    end

    assign busy      = (state == SETTLE) || (state == CHECK);
    assign done      = (state == FIN);
    assign state_dbg = state;

endmodule

// File: tb/tb_minterm_sweep_checker.sv
// Bench for minterm_sweep_checker. It has two instances: u0 (N_IN=4, SETTLE_CYCLES=1)
// and u1 (N_IN=3, SETTLE_CYCLES=3). Each lab DUT is modelled as a truth table that sel
// indexes. The reference computes the expected counts by walking the mask and the table.
// It computes the expected sel for cycle k after the start edge as k/(SETTLE_CYCLES+1).
module tb_minterm_sweep_checker;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, start0, dut_o0, busy0, done0, pass0, ffv0;
    logic [15:0] mask0, tbl0;
    logic [3:0]  sel0, ff0;
    logic [4:0]  miss0, extra0;
    logic [1:0]  st0;

    logic        rst1, start1, dut_o1, busy1, done1, pass1, ffv1, and_mode1;
    logic [7:0]  mask1, tbl1;
    logic [2:0]  sel1, ff1;
    logic [3:0]  miss1, extra1;
    logic [1:0]  st1;

    assign dut_o0 = tbl0[sel0];
    assign dut_o1 = and_mode1 ? (&sel1) : tbl1[sel1];

    minterm_sweep_checker #(.N_IN(4), .SETTLE_CYCLES(1)) u0 (
        .clk(clk), .rst(rst0), .start(start0), .minterm_mask(mask0), .dut_o(dut_o0),
        .sel(sel0), .busy(busy0), .done(done0), .pass(pass0), .miss_cnt(miss0),
        .extra_cnt(extra0), .first_fail(ff0), .first_fail_vld(ffv0), .state_dbg(st0)
    );

    minterm_sweep_checker #(.N_IN(3), .SETTLE_CYCLES(3)) u1 (
        .clk(clk), .rst(rst1), .start(start1), .minterm_mask(mask1), .dut_o(dut_o1),
        .sel(sel1), .busy(busy1), .done(done1), .pass(pass1), .miss_cnt(miss1),
        .extra_cnt(extra1), .first_fail(ff1), .first_fail_vld(ffv1), .state_dbg(st1)
    );

    // ---------------- scoreboard ----------------
    int vectors = 0;
    int miscompares = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sample(input int w, output logic [31:0] o_sel, output logic [31:0] o_busy,
                          output logic [31:0] o_done, output logic [31:0] o_pass,
                          output logic [31:0] o_miss, output logic [31:0] o_extra,
                          output logic [31:0] o_ff, output logic [31:0] o_ffv);
        if (w == 0) begin
            o_sel = 32'(sel0); o_busy = 32'(busy0); o_done = 32'(done0); o_pass = 32'(pass0);
            o_miss = 32'(miss0); o_extra = 32'(extra0); o_ff = 32'(ff0); o_ffv = 32'(ffv0);
        end else begin
            o_sel = 32'(sel1); o_busy = 32'(busy1); o_done = 32'(done1); o_pass = 32'(pass1);
            o_miss = 32'(miss1); o_extra = 32'(extra1); o_ff = 32'(ff1); o_ffv = 32'(ffv1);
        end
    endtask

    // Reference model over vectors 0..upto-1.
    function automatic void model(input logic [15:0] mask, input logic [15:0] eff, input int upto,
                                  output int miss, output int extra, output int ff, output int vld);
        miss = 0; extra = 0; ff = 0; vld = 0;
        for (int i = 0; i < upto; i++) begin
            if (mask[i] && !eff[i]) miss++;
            if (!mask[i] && eff[i]) extra++;
            if ((mask[i] != eff[i]) && (vld == 0)) begin
                ff = i;
                vld = 1;
            end
        end
    endfunction

    // ---------------- driver tasks ----------------
    task automatic start_pulse(input int w, input logic [15:0] mask);
        @(negedge clk);
        if (w == 0) begin mask0 = mask; start0 = 1'b1; end
        else begin mask1 = mask[7:0]; start1 = 1'b1; end
        @(posedge clk);
        #1;
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    // Call this #1 after the start-accept edge. It checks every cycle up to and including
    // the cycle after done.
    task automatic watch_sweep(input int w, input logic [15:0] mask, input logic [15:0] eff,
                               input bit disturb, input bit fin_start);
        int vec, hold, total, m, e, ff, vld;
        logic [31:0] s, b, d, p, mi, ex, f, fv;
        vec   = (w == 0) ? 16 : 8;
        hold  = (w == 0) ? 2 : 4;
        total = vec * hold;
        model(mask, eff, vec, m, e, ff, vld);
        exp_q.delete();
        for (int k = 0; k <= total; k++)
            exp_q.push_back(32'((k / hold < vec) ? k / hold : vec - 1));
        for (int cyc = 0; cyc <= total; cyc++) begin
            @(negedge clk);
            sample(w, s, b, d, p, mi, ex, f, fv);
            check($sformatf("sel[w%0d c%0d]", w, cyc), s, exp_q.pop_front());
            check($sformatf("busy[w%0d c%0d]", w, cyc), b, 32'(cyc < total));
            check($sformatf("done[w%0d c%0d]", w, cyc), d, 32'(cyc == total));
            if (disturb && w == 0 && cyc == 9) begin start0 = 1'b1; mask0 = 16'hFFFF; end
            if (disturb && w == 0 && cyc == 10) start0 = 1'b0;
            if (cyc == total) begin
                check("pass_at_done", p, 32'((m == 0) && (e == 0)));
                check("miss_cnt", mi, 32'(m));
                check("extra_cnt", ex, 32'(e));
                check("first_fail_vld", fv, 32'(vld));
                if (vld != 0) check("first_fail", f, 32'(ff));
                if (fin_start) begin
                    if (w == 0) start0 = 1'b1; else start1 = 1'b1;
                end
            end
        end
        // Check the IDLE cycle after FIN. The results must hold, and a start seen in FIN must be ignored.
        @(negedge clk);
        sample(w, s, b, d, p, mi, ex, f, fv);
        check("idle_busy", b, 32'h0);
        check("idle_done", d, 32'h0);
        check("idle_pass_hold", p, 32'((m == 0) && (e == 0)));
        check("idle_miss_hold", mi, 32'(m));
        check("idle_extra_hold", ex, 32'(e));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int m, e, ff, vld;
        logic [15:0] rm, rt;
        rst0 = 1'b1; start0 = 1'b0; mask0 = '0; tbl0 = '0;
        rst1 = 1'b1; start1 = 1'b0; mask1 = '0; tbl1 = '0; and_mode1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst0 = 1'b0; rst1 = 1'b0;
        @(negedge clk);
        check("rst_sel0", 32'(sel0), 32'h0);
        check("rst_busy0", 32'(busy0), 32'h0);
        check("rst_done0", 32'(done0), 32'h0);
        check("rst_pass0", 32'(pass0), 32'h0);
        check("rst_miss0", 32'(miss0), 32'h0);
        check("rst_extra0", 32'(extra0), 32'h0);
        check("rst_ff0", 32'(ff0), 32'h0);
        check("rst_ffv0", 32'(ffv0), 32'h0);
        check("rst_state0", 32'(st0), 32'h0);
        check("rst_sel1", 32'(sel1), 32'h0);
        check("rst_busy1", 32'(busy1), 32'h0);

        // The golden DUT matches mask A888 (minterms 3, 7, 11, 13, 15).
        tbl0 = 16'hA888;
        start_pulse(0, 16'hA888);
        watch_sweep(0, 16'hA888, 16'hA888, 0, 0);

        // The DUT is tied to 0. Expect 5 misses, with the first fail at vector 3.
        tbl0 = 16'h0000;
        start_pulse(0, 16'hA888);
        watch_sweep(0, 16'hA888, 16'h0000, 0, 0);

        // The DUT is tied to 1. Expect 11 extras, with the first fail at vector 0.
        tbl0 = 16'hFFFF;
        start_pulse(0, 16'hA888);
        watch_sweep(0, 16'hA888, 16'hFFFF, 0, 0);

        // A second start and a new mask arrive mid-sweep. Both must have no effect.
        tbl0 = 16'hA888;
        start_pulse(0, 16'hA888);
        watch_sweep(0, 16'hA888, 16'hA888, 1, 0);

        // Assert reset at edge 15 of a failing sweep.
        tbl0 = 16'h0000;
        start_pulse(0, 16'hA888);
        repeat (15) @(negedge clk);
        model(16'hA888, 16'h0000, 7, m, e, ff, vld);
        check("pre_rst_miss", 32'(miss0), 32'(m));
        check("pre_rst_ffv", 32'(ffv0), 32'(vld));
        rst0 = 1'b1;
        @(posedge clk);
        #1;
        rst0 = 1'b0;
        @(negedge clk);
        check("abort_sel", 32'(sel0), 32'h0);
        check("abort_busy", 32'(busy0), 32'h0);
        check("abort_done", 32'(done0), 32'h0);
        check("abort_pass", 32'(pass0), 32'h0);
        check("abort_miss", 32'(miss0), 32'h0);
        check("abort_extra", 32'(extra0), 32'h0);
        check("abort_ff", 32'(ff0), 32'h0);
        check("abort_ffv", 32'(ffv0), 32'h0);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            check("abort_no_done", 32'(done0), 32'h0);
        end
        tbl0 = 16'hA888;
        start_pulse(0, 16'hA888);
        watch_sweep(0, 16'hA888, 16'hA888, 0, 0);

        // A start held through FIN is ignored in FIN and accepted in the following IDLE cycle.
        rm = 16'($urandom);
        tbl0 = rm ^ 16'($urandom & $urandom);
        start_pulse(0, rm);
        watch_sweep(0, rm, tbl0, 0, 1);
        @(posedge clk);
        #1;
        start0 = 1'b0;
        watch_sweep(0, rm, tbl0, 0, 0);

        // N_IN=3 with SETTLE_CYCLES=3. The DUT is an AND3 and the mask is 8'h80.
        and_mode1 = 1'b1;
        start_pulse(1, 16'h0080);
        watch_sweep(1, 16'h0080, 16'h0080, 0, 0);

        // Random masks against sparsely corrupted tables.
        for (int r = 0; r < 4; r++) begin
            rm = 16'($urandom);
            rt = rm ^ 16'($urandom & $urandom & $urandom);
            tbl0 = rt;
            start_pulse(0, rm);
            watch_sweep(0, rm, rt, 0, 0);
        end
        and_mode1 = 1'b0;
        for (int r = 0; r < 2; r++) begin
            rm = {8'h00, 8'($urandom_range(0, 255))};
            rt = {8'h00, rm[7:0] ^ 8'($urandom & $urandom)};
            tbl1 = rt[7:0];
            start_pulse(1, rm);
            watch_sweep(1, rm, rt, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
